alu_seq: RTL and testbench

- Parametrised, handshaked successor to the datapath ALU: integer add/sub with a persistent carry flag, logic ops, and a multi-cycle shift-add multiplier.
- Sits between the register-read stage and writeback; stalls upstream through valid/ready while a multiply runs or writeback back-pressures.
- Adds registered status flags and an error flag on unsupported opcodes.

---
 rtl/alu_seq.sv | 216 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a persistent carry flag, logic ops, registered
// status flags, an error flag for unsupported opcodes and an optional
// iterative shift-add multiplier.
// Optional feature macro: ALU_SEQ_MUL_EN
// (defined: multiplier and MUL_RUN present; undefined: opcode 4 is illegal).
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_z,
  output logic                 flag_n,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic                 flag_err
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDC = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SUBB = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_NAND = 5'd11;
  localparam logic [4:0] OP_NOR  = 5'd12;
  localparam logic [4:0] OP_XNOR = 5'd13;
  localparam logic [4:0] OP_NOT  = 5'd14;
  localparam logic [4:0] OP_NEG  = 5'd15;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam int         CNT_W   = $clog2(WIDTH) + 1;
  typedef enum logic [0:0] {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   result_reg, result_next;
  logic                 out_valid_reg, out_valid_next;
  logic                 carry_reg, carry_next;
  logic                 z_reg, z_next, n_reg, n_next, v_reg, v_next, err_reg, err_next;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic [2*WIDTH-1:0]   prod_reg, prod_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   prod_step;
`endif

  // single-cycle datapath: one shared adder serves add/sub/NEG
  logic [WIDTH-1:0]     add_a, add_b;
  logic                 add_cin;
  logic [WIDTH:0]       sum_full;
  logic                 use_add, alu_arith, alu_is_mul, alu_err, alu_v;
  logic [2*WIDTH-1:0]   alu_res;
  logic                 accept;

  assign in_ready  = (state_reg == IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flag_z    = z_reg;
  assign flag_n    = n_reg;
  assign flag_c    = carry_reg;
  assign flag_v    = v_reg;
  assign flag_err  = err_reg;

  // opcode decode and single-cycle result/overflow computation
  always_comb begin
    add_a      = op_a;
    add_b      = op_b;
    add_cin    = 1'b0;
    use_add    = 1'b0;
    alu_arith  = 1'b0;
    alu_is_mul = 1'b0;
    alu_err    = 1'b0;
    alu_v      = 1'b0;
    alu_res    = '0;
    case (opcode)
      OP_ADD:  begin use_add = 1'b1; alu_arith = 1'b1; end
      OP_ADDC: begin use_add = 1'b1; alu_arith = 1'b1; add_cin = carry_reg; end
      OP_SUB:  begin use_add = 1'b1; alu_arith = 1'b1; add_b = ~op_b; add_cin = 1'b1; end
      OP_SUBB: begin use_add = 1'b1; alu_arith = 1'b1; add_b = ~op_b; add_cin = carry_reg; end
      OP_NEG:  begin use_add = 1'b1; add_a = '0; add_b = ~op_a; add_cin = 1'b1; end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  alu_is_mul = 1'b1;
`endif
      OP_AND:  alu_res = {{WIDTH{1'b0}}, op_a & op_b};
      OP_OR:   alu_res = {{WIDTH{1'b0}}, op_a | op_b};
      OP_XOR:  alu_res = {{WIDTH{1'b0}}, op_a ^ op_b};
      OP_NAND: alu_res = {{WIDTH{1'b0}}, ~(op_a & op_b)};
      OP_NOR:  alu_res = {{WIDTH{1'b0}}, ~(op_a | op_b)};
      OP_XNOR: alu_res = {{WIDTH{1'b0}}, ~(op_a ^ op_b)};
      OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~op_a};
      default: alu_err = 1'b1;
    endcase
    sum_full = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    if (use_add) begin
      // NEG drops the carry-out from the result; add/sub expose it at bit WIDTH
      alu_res = alu_arith ? {{(WIDTH-1){1'b0}}, sum_full}
                          : {{WIDTH{1'b0}}, sum_full[WIDTH-1:0]};
      alu_v   = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                (sum_full[WIDTH-1] != add_a[WIDTH-1]);
    end
  end

`ifdef ALU_SEQ_MUL_EN
  assign prod_step = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif

  // next-state, result and flag update; everything holds by default
  always_comb begin
    state_next     = state_reg;
    result_next    = result_reg;
    out_valid_next = out_valid_reg;
    carry_next     = carry_reg;
    z_next         = z_reg;
    n_next         = n_reg;
    v_next         = v_reg;
    err_next       = err_reg;
`ifdef ALU_SEQ_MUL_EN
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
    prod_next      = prod_reg;
    cnt_next       = cnt_reg;
`endif
    if (out_valid_reg && out_ready) out_valid_next = 1'b0;
    if (state_reg == IDLE) begin
      if (accept) begin
        if (alu_is_mul) begin
`ifdef ALU_SEQ_MUL_EN
          state_next     = MUL_RUN;
          mcand_next     = {{WIDTH{1'b0}}, op_a};
          mplier_next    = op_b;
          prod_next      = '0;
          cnt_next       = CNT_W'(WIDTH);
          out_valid_next = 1'b0;
`endif
        end else begin
          result_next    = alu_res;
          out_valid_next = 1'b1;
          z_next         = (alu_res[WIDTH-1:0] == '0);
          n_next         = alu_res[WIDTH-1];
          v_next         = alu_v;
          err_next       = alu_err;
          if (alu_arith) carry_next = sum_full[WIDTH];
        end
      end
    end
`ifdef ALU_SEQ_MUL_EN
    else begin
      // one shift-add step per edge; the last step publishes the product
      prod_next   = prod_step;
      mcand_next  = mcand_reg << 1;
      mplier_next = mplier_reg >> 1;
      cnt_next    = cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) begin
        state_next     = IDLE;
        result_next    = prod_step;
        out_valid_next = 1'b1;
        z_next         = (prod_step == '0);
        n_next         = prod_step[2*WIDTH-1];
        v_next         = 1'b0;
        err_next       = 1'b0;
      end
    end
`endif
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      result_reg    <= '0;
      out_valid_reg <= 1'b0;
      carry_reg     <= 1'b0;
      z_reg         <= 1'b0;
      n_reg         <= 1'b0;
      v_reg         <= 1'b0;
      err_reg       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      prod_reg      <= '0;
      cnt_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      result_reg    <= result_next;
      out_valid_reg <= out_valid_next;
      carry_reg     <= carry_next;
      z_reg         <= z_next;
      n_reg         <= n_next;
      v_reg         <= v_next;
      err_reg       <= err_next;
`ifdef ALU_SEQ_MUL_EN
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
      prod_reg      <= prod_next;
      cnt_reg       <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=32): table of directed vectors plus hand-written
// sequences for multiply latency, back-to-back issue, back-pressure and reset.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        flag_z, flag_n, flag_c, flag_v, flag_err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic [4:0]  fl;   // {err, v, c, n, z}
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input logic [4:0] fl);
    vec_t v;
    v.opc = opc; v.a = a; v.b = b; v.res = res; v.fl = fl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  function automatic logic [5:0] flags_now();
    return {out_valid, flag_err, flag_v, flag_c, flag_n, flag_z};
  endfunction

  // offer one op at the falling edge, wait (bounded) for acceptance, return #1 after the accept edge
  task automatic do_op(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    opcode = opc; op_a = a; op_b = b; in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int edges;
    logic ready_bad;

    rst = 1'b1; in_valid = 1'b0; opcode = '0; op_a = '0; op_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_result", result, 64'd0);
    check("reset_flags", {58'd0, flags_now()}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // {err, v, c, n, z}; order matters because the carry register chains
    add_vec(5'd0,  32'hFFFFFFFF, 32'h1,        64'h1_00000000, 5'b00101);
    add_vec(5'd1,  32'h0,        32'h0,        64'h1,          5'b00000);
    add_vec(5'd2,  32'd5,        32'd7,        64'hFFFFFFFE,   5'b00010);
    add_vec(5'd3,  32'd10,       32'd3,        64'h1_00000006, 5'b00100);
    add_vec(5'd0,  32'h7FFFFFFF, 32'h1,        64'h80000000,   5'b01010);
    add_vec(5'd2,  32'd3,        32'd3,        64'h1_00000000, 5'b00101);
    add_vec(5'd15, 32'h80000000, 32'h0,        64'h80000000,   5'b01110);
    add_vec(5'd5,  32'd123,      32'd456,      64'h0,          5'b10101);
    add_vec(5'd8,  32'hF0F0F0F0, 32'hFF00FF00, 64'hF000F000,   5'b00110);
    add_vec(5'd9,  32'h0F0F0000, 32'h000000F0, 64'h0F0F00F0,   5'b00100);
    add_vec(5'd10, 32'hAAAAAAAA, 32'h55555555, 64'hFFFFFFFF,   5'b00110);
    add_vec(5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,          5'b00101);
    add_vec(5'd12, 32'h0,        32'h0,        64'hFFFFFFFF,   5'b00110);
    add_vec(5'd13, 32'h12345678, 32'h12345678, 64'hFFFFFFFF,   5'b00110);
    add_vec(5'd14, 32'hFFFFFFFF, 32'h0,        64'h0,          5'b00101);
    add_vec(5'd15, 32'h1,        32'h0,        64'hFFFFFFFF,   5'b00110);
    add_vec(5'd31, 32'h5,        32'h6,        64'h0,          5'b10101);
    add_vec(5'd1,  32'h1,        32'h1,        64'h3,          5'b00000);
    add_vec(5'd2,  32'h0,        32'h0,        64'h1_00000000, 5'b00101);
    add_vec(5'd3,  32'd10,       32'd3,        64'h1_00000007, 5'b00100);
    add_vec(5'd2,  32'h80000000, 32'h1,        64'h1_7FFFFFFF, 5'b01100);

    foreach (vecs[i]) begin
      do_op(vecs[i].opc, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_op%0d_result", i, vecs[i].opc), result, vecs[i].res);
      check($sformatf("vec%0d_op%0d_flags", i, vecs[i].opc), {58'd0, flags_now()}, {58'd0, 1'b1, vecs[i].fl});
    end

`ifdef ALU_SEQ_MUL_EN
    // multiply: result exactly 32 edges after accept, carry (1) untouched
    do_op(5'd4, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("mul_valid_cleared", {63'd0, out_valid}, 64'd0);
    check("mul_in_ready_low", {63'd0, in_ready}, 64'd0);
    edges = 0;
    ready_bad = 1'b0;
    while (edges < 100) begin
      op_a = $urandom; op_b = $urandom;
      @(posedge clk);
      #1 edges++;
      if (out_valid) break;
      if (in_ready) ready_bad = 1'b1;
    end
    check("mul_latency", 64'(edges), 64'd32);
    check("mul_in_ready_during_run", {63'd0, ready_bad}, 64'd0);
    check("mul_result", result, 64'hFFFFFFFE00000001);
    check("mul_flags", {58'd0, flags_now()}, {58'd0, 6'b100110});
`else
    // multiplier absent: opcode 4 is illegal with latency 1
    do_op(5'd4, 32'd3, 32'd5);
    check("mul_off_result", result, 64'd0);
    check("mul_off_flags", {58'd0, flags_now()}, {58'd0, 6'b110101});
`endif

    // back-to-back ADDs, one result per edge
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      opcode = 5'd0; op_a = 32'(i * 10); op_b = 32'(i); in_valid = 1'b1;
      check($sformatf("b2b%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1 check($sformatf("b2b%0d_result", i), result, 64'(i * 11));
      check($sformatf("b2b%0d_valid", i), {63'd0, out_valid}, 64'd1);
    end

    // back-pressure: result holds and the next op waits until out_ready returns
    @(negedge clk);
    opcode = 5'd0; op_a = 32'd100; op_b = 32'd200; in_valid = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    op_a = 32'd1; op_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
      check($sformatf("bp%0d_result", i), result, 64'd300);
      check($sformatf("bp%0d_valid", i), {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 check("bp_next_result", result, 64'd2);
    in_valid = 1'b0;
    @(posedge clk);
    #1 check("drain_valid_clear", {63'd0, out_valid}, 64'd0);

    // reset mid-operation clears carry, flags and output
    do_op(5'd2, 32'h0, 32'h0);
    check("pre_reset_carry", {63'd0, flag_c}, 64'd1);
`ifdef ALU_SEQ_MUL_EN
    do_op(5'd4, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_flags", {58'd0, flags_now()}, 64'd0);
    check("rst_mid_result", result, 64'd0);
    check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    do_op(5'd1, 32'd1, 32'd1);
    check("post_rst_addc_result", result, 64'd2);
    check("post_rst_addc_flags", {58'd0, flags_now()}, {58'd0, 6'b100000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
